// File: rtl/piso_serializer_pkg.sv
// Shared constants, state encoding and counter sizing for the serializer.
// No logic, no latency, no backpressure.
// Imported by piso_serializer and its bit counter.
package piso_serializer_pkg;

    localparam int DEFAULT_B = 18;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of a counter that must reach b-1; never narrower than one bit.
    function automatic int cnt_width(input int b);
        return ($clog2(b) < 1) ? 1 : $clog2(b);
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit-position counter with synchronous clear, increment enable and terminal flag.
// tc is combinational from the count register; updates one cycle after clr/inc.
// No backpressure; the owner gates inc so the count never passes B-1.
module piso_serializer_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int B = DEFAULT_B,
    parameter int W = cnt_width(B)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(B - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out reader: loads a B-bit word and drains it MSB first.
// First bit appears the cycle after the load edge; one bit per out_en cycle, no bubble between words.
// out_en = 0 stalls the stream indefinitely; in_ready only rises in IDLE or on the last-bit consume.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int B = DEFAULT_B
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [B-1:0] in,
    output logic         in_ready,
    input  logic         out_en,
    output logic         out_valid,
    output logic         out_bit,
    output logic         out_last
);

    state_t       state;
    state_t       state_nxt;
    logic [B-1:0] sreg;
    logic [B-1:0] sreg_nxt;
    logic         tc;
    logic         load;
    logic         advance;

    piso_serializer_bit_counter #(
        .B (B)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .inc (advance),
        .tc  (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        out_valid = (state == SHIFT);
        out_bit   = out_valid & sreg[B-1];
        out_last  = out_valid & tc;
        // in_ready must not depend on in_valid, so it is built from state, tc and out_en only.
        in_ready  = (state == IDLE) | (out_last & out_en);
        load      = in_ready & in_valid;
        advance   = out_valid & out_en & ~tc;

        if (load) begin
            sreg_nxt  = in;
            state_nxt = SHIFT;
        end else if (advance) begin
            sreg_nxt  = {sreg[B-2:0], 1'b0};
        end else if (out_last && out_en) begin
            state_nxt = IDLE;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: constant tables and directed sequences for the corner cases,
// then random traffic, all cross-checked against a bit-queue model of the serial stream.
module tb_piso_serializer;

    localparam int B = 18;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [B-1:0] in_w = '0;
    logic         out_en = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         out_bit;
    logic         out_last;

    int vecs = 0;
    int errs = 0;

    // Model: the bits still owed to the consumer, oldest first.
    bit q[$];
    // Bits actually taken by the consumer (out_valid & out_en).
    bit cap[$];

    typedef struct {
        logic         en;
        logic         v;
        logic [B-1:0] d;
        logic         rdy;
        logic         vld;
        logic         bt;
        logic         last;
    } vec_t;

    vec_t tbl[20];

    piso_serializer #(.B(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in_w),
        .in_ready  (in_ready),
        .out_en    (out_en),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic act, input logic exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cyc(input logic en, input logic v, input logic [B-1:0] d, input string tag,
                       output logic o_rdy, output logic o_vld, output logic o_bit, output logic o_last);
        logic e_rdy, e_vld, e_bit, e_last;
        out_en   = en;
        in_valid = v;
        in_w     = d;
        #1;
        e_vld  = (q.size() > 0);
        e_last = (q.size() == 1);
        e_bit  = 1'b0;
        if (e_vld) e_bit = q[0];
        e_rdy  = !e_vld || (e_last && en);
        chk({tag, ".in_ready"},  in_ready,  e_rdy);
        chk({tag, ".out_valid"}, out_valid, e_vld);
        chk({tag, ".out_bit"},   out_bit,   e_bit);
        chk({tag, ".out_last"},  out_last,  e_last);
        o_rdy  = in_ready;
        o_vld  = out_valid;
        o_bit  = out_bit;
        o_last = out_last;
        if (out_valid === 1'b1 && en) cap.push_back(out_bit);
        @(posedge clk);
        if (e_vld && en) void'(q.pop_front());
        if (e_rdy && v) begin
            for (int i = B - 1; i >= 0; i--) q.push_back(d[i]);
        end
        @(negedge clk);
    endtask

    task automatic step(input logic en, input logic v, input logic [B-1:0] d, input string tag);
        logic r, vl, b, l;
        cyc(en, v, d, tag, r, vl, b, l);
    endtask

    task automatic check_cap(input string tag, input logic [2*B-1:0] exp, input int n);
        chk_int({tag, ".bit_count"}, cap.size(), n);
        for (int i = 0; i < n && i < cap.size(); i++) begin
            chk($sformatf("%s.bit%0d", tag, i), cap[i], exp[n-1-i]);
        end
        cap.delete();
    endtask

    initial begin
        logic         r, vl, b, l;
        logic         sb, sl;
        logic [B-1:0] pat;
        int           pulses;

        // Reset then idle: asserted at 17 ns, released at 29 ns.
        #17 rst = 1'b0;
        #1;
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.out_bit", out_bit, 1'b0);
        chk("rst.out_last", out_last, 1'b0);
        #8;
        chk("rst_hold.in_ready", in_ready, 1'b1);
        chk("rst_hold.out_valid", out_valid, 1'b0);
        chk("rst_hold.out_bit", out_bit, 1'b0);
        #3 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, "idle");

        // Single word 18'h2A5F3 from a constant table.
        pat = 18'b101010010111110011;
        tbl[0] = '{en: 1'b1, v: 1'b1, d: 18'h2A5F3, rdy: 1'b1, vld: 1'b0, bt: 1'b0, last: 1'b0};
        for (int i = 0; i < B; i++) begin
            tbl[i+1] = '{en: 1'b1, v: 1'b0, d: '0, rdy: (i == B - 1), vld: 1'b1,
                         bt: pat[B-1-i], last: (i == B - 1)};
        end
        tbl[19] = '{en: 1'b1, v: 1'b0, d: '0, rdy: 1'b1, vld: 1'b0, bt: 1'b0, last: 1'b0};
        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].en, tbl[i].v, tbl[i].d, $sformatf("tbl%0d", i), r, vl, b, l);
            chk($sformatf("tbl%0d.in_ready", i), r, tbl[i].rdy);
            chk($sformatf("tbl%0d.out_valid", i), vl, tbl[i].vld);
            chk($sformatf("tbl%0d.out_bit", i), b, tbl[i].bt);
            chk($sformatf("tbl%0d.out_last", i), l, tbl[i].last);
        end
        check_cap("single", {18'd0, 18'h2A5F3}, B);

        // Stall after the 3rd bit for 5 cycles.
        step(1'b1, 1'b1, 18'd12, "stall_ld");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, "stall_pre");
        cyc(1'b0, 1'b0, '0, "stall_first", r, vl, sb, sl);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, '0, "stall", r, vl, b, l);
            chk("stall.bit_frozen", b, sb);
            chk("stall.last_frozen", l, sl);
        end
        for (int i = 0; i < B - 3; i++) step(1'b1, 1'b0, '0, "stall_post");
        step(1'b1, 1'b0, '0, "stall_idle");
        check_cap("stall", {18'd0, 18'd12}, B);

        // Back-to-back: 27 then 192 with in_valid held high.
        step(1'b1, 1'b1, 18'd27, "b2b_ld");
        pulses = 0;
        for (int i = 0; i < B; i++) begin
            cyc(1'b1, 1'b1, 18'd192, "b2b_a", r, vl, b, l);
            chk($sformatf("b2b.in_ready%0d", i), r, (i == B - 1));
            if (r === 1'b1) pulses++;
        end
        chk_int("b2b.ready_pulses", pulses, 1);
        for (int i = 0; i < B; i++) step(1'b1, 1'b0, '0, "b2b_b");
        step(1'b1, 1'b0, '0, "b2b_idle");
        check_cap("b2b", {18'd27, 18'd192}, 2 * B);

        // Reset after 7 bits of 192.
        step(1'b1, 1'b1, 18'd192, "mid_ld");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, '0, "mid_pre");
        rst = 1'b0;
        #1;
        chk("mid_rst.in_ready", in_ready, 1'b1);
        chk("mid_rst.out_valid", out_valid, 1'b0);
        chk("mid_rst.out_bit", out_bit, 1'b0);
        chk("mid_rst.out_last", out_last, 1'b0);
        q.delete();
        cap.delete();
        #3 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, "mid_idle");
        step(1'b1, 1'b1, 18'd192, "mid_reload");
        for (int i = 0; i < B; i++) step(1'b1, 1'b0, '0, "mid_post");
        check_cap("mid_reload", {18'd0, 18'd192}, B);

        // in and in_valid ignored mid-word.
        step(1'b1, 1'b1, 18'h30F0F, "ign_ld");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, "ign_pre");
        cyc(1'b1, 1'b1, 18'h1FFFF, "ign_poke", r, vl, b, l);
        chk("ign.in_ready", r, 1'b0);
        for (int i = 0; i < B - 5; i++) step(1'b1, 1'b0, 18'h2AAAA, "ign_post");
        step(1'b1, 1'b0, '0, "ign_idle");
        check_cap("ignored", {18'd0, 18'h30F0F}, B);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 B'($urandom), "rand");
        end
        cap.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
